cpu_program_sequencer: RTL and testbench

//  Drives the 4-bit accumulator CPU's 8-bit command port {cmdarg[3:0], 1'b0, cmd[1:0], cpu_clk}

---
 rtl/cpu_program_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_program_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_program_sequencer
// Description : Drives the 4-bit accumulator CPU command port from the system
//               clock: Reset, load DEPTH code + DEPTH data words from a
//               valid/ready source, Reset, then Run until a pc fixed point
//               or the step budget expires, and report status.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_program_sequencer #(
    parameter int DEPTH     = 16,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_data,
    output logic [7:0]        cpu_io_in,
    input  logic [7:0]        cpu_io_out,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic [STEP_W-1:0] steps,
    output logic [3:0]        result_acc
);

    localparam int                 c_CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(DEPTH - 1);
    localparam logic [STEP_W-1:0]  c_MAX     = STEP_W'(MAX_STEPS);
    localparam logic [1:0]         c_CMD_RST = 2'd0;
    localparam logic [1:0]         c_CMD_LDC = 2'd1;
    localparam logic [1:0]         c_CMD_LDD = 2'd2;
    localparam logic [1:0]         c_CMD_RUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST1 = 3'd1,
        S_LDC  = 3'd2,
        S_LDD  = 3'd3,
        S_RST2 = 3'd4,
        S_RUN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic                r_phase,   w_phase_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [1:0]          r_cmd,     w_cmd_nxt;
    logic [3:0]          r_arg,     w_arg_nxt;
    logic                r_cpu_clk, w_cpu_clk_nxt;
    logic [3:0]          r_pc_prev, w_pc_prev_nxt;
    logic [STEP_W-1:0]   r_steps,   w_steps_nxt;
    logic                r_halted,  w_halted_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic [3:0]          r_acc,     w_acc_nxt;
    logic [3:0]          w_pc;

    assign w_pc       = cpu_io_out[7:4];
    assign cpu_io_in  = {r_arg, 1'b0, r_cmd, r_cpu_clk};
    assign in_ready   = ((r_state == S_LDC) || (r_state == S_LDD)) && !r_phase;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign halted     = r_halted;
    assign timeout    = r_timeout;
    assign steps      = r_steps;
    assign result_acc = r_acc;

    // Next-state and next-command decode; every command is phase 0 (cpu_clk low,
    // command set up) followed by phase 1 (cpu_clk high, command held).
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_cmd_nxt     = r_cmd;
        w_arg_nxt     = r_arg;
        w_cpu_clk_nxt = r_cpu_clk;
        w_pc_prev_nxt = r_pc_prev;
        w_steps_nxt   = r_steps;
        w_halted_nxt  = r_halted;
        w_timeout_nxt = r_timeout;
        w_acc_nxt     = r_acc;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_RST1;
                    w_phase_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
                    w_cmd_nxt     = c_CMD_RST;
                    w_arg_nxt     = 4'd0;
                    w_cpu_clk_nxt = 1'b0;
                    w_steps_nxt   = '0;
                    w_halted_nxt  = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_RST1, S_RST2: begin
                if (!r_phase) begin
                    w_phase_nxt   = 1'b1;
                    w_cpu_clk_nxt = 1'b1;
                end else begin
                    w_phase_nxt   = 1'b0;
                    w_cpu_clk_nxt = 1'b0;
                    w_arg_nxt     = 4'd0;
                    if (r_state == S_RST1) begin
                        w_state_nxt = S_LDC;
                        w_cmd_nxt   = c_CMD_LDC;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cmd_nxt   = c_CMD_RUN;
                    end
                end
            end
            S_LDC, S_LDD: begin
                if (!r_phase) begin
                    // Without a word the CPU edge is simply withheld.
                    if (in_valid) begin
                        w_phase_nxt   = 1'b1;
                        w_cpu_clk_nxt = 1'b1;
                        w_arg_nxt     = (r_state == S_LDC) ? {2'b00, in_data[1:0]} : in_data;
                    end
                end else begin
                    w_phase_nxt   = 1'b0;
                    w_cpu_clk_nxt = 1'b0;
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_state == S_LDC) begin
                            w_state_nxt = S_LDD;
                            w_cmd_nxt   = c_CMD_LDD;
                        end else begin
                            w_state_nxt = S_RST2;
                            w_cmd_nxt   = c_CMD_RST;
                            w_arg_nxt   = 4'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (!r_phase) begin
                    // A pc that did not move over the last step is a halt; it
                    // wins over an exhausted budget seen in the same cycle.
                    if ((r_steps != '0) && (w_pc == r_pc_prev)) begin
                        w_state_nxt  = S_DONE;
                        w_halted_nxt = 1'b1;
                        w_acc_nxt    = cpu_io_out[3:0];
                    end else if (r_steps == c_MAX) begin
                        w_state_nxt   = S_DONE;
                        w_timeout_nxt = 1'b1;
                        w_acc_nxt     = cpu_io_out[3:0];
                    end else begin
                        w_pc_prev_nxt = w_pc;
                        w_phase_nxt   = 1'b1;
                        w_cpu_clk_nxt = 1'b1;
                        if (r_steps != c_MAX) begin
                            w_steps_nxt = r_steps + STEP_W'(1);
                        end
                    end
                end else begin
                    w_phase_nxt   = 1'b0;
                    w_cpu_clk_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_phase_nxt   = 1'b0;
                w_cmd_nxt     = c_CMD_RST;
                w_arg_nxt     = 4'd0;
                w_cpu_clk_nxt = 1'b0;
            end
        endcase
    end

    // State and registered command port; cpu_clk comes straight from a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_phase   <= 1'b0;
            r_cnt     <= '0;
            r_cmd     <= c_CMD_RST;
            r_arg     <= 4'd0;
            r_cpu_clk <= 1'b0;
            r_pc_prev <= 4'd0;
            r_steps   <= '0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_acc     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_arg     <= w_arg_nxt;
            r_cpu_clk <= w_cpu_clk_nxt;
            r_pc_prev <= w_pc_prev_nxt;
            r_steps   <= w_steps_nxt;
            r_halted  <= w_halted_nxt;
            r_timeout <= w_timeout_nxt;
            r_acc     <= w_acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_program_sequencer
// Description : Self-checking bench for cpu_program_sequencer with a small
//               accumulator CPU attached to the command port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_program_sequencer;

    localparam int c_DEPTH = 16;
    localparam int c_STEPW = 8;
    localparam int c_MAXS  = 20;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_data;
    logic [7:0]         cpu_io_in;
    logic [7:0]         cpu_io_out;
    logic               busy;
    logic               done;
    logic               halted;
    logic               timeout;
    logic [c_STEPW-1:0] steps;
    logic [3:0]         result_acc;

    int errors = 0;
    int checks = 0;

    cpu_program_sequencer #(
        .DEPTH     (c_DEPTH),
        .STEP_W    (c_STEPW),
        .MAX_STEPS (c_MAXS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cpu_io_in  (cpu_io_in),
        .cpu_io_out (cpu_io_out),
        .busy       (busy),
        .done       (done),
        .halted     (halted),
        .timeout    (timeout),
        .steps      (steps),
        .result_acc (result_acc)
    );

    always #5 clock = ~clock;

    // Attached CPU: ops 0 Load, 1 Bnz (jump to data[pc] if acc!=0), 2 Add, 3 Jmp.
    logic       cpu_clk;
    logic [1:0] m_code [c_DEPTH];
    logic [3:0] m_data [c_DEPTH];
    logic [3:0] m_pc, m_acc, m_ptr;
    assign cpu_clk    = cpu_io_in[0];
    assign cpu_io_out = {m_pc, m_acc};

    // CPU captures its command on the rising edge of cpu_clk.
    always @(posedge cpu_clk) begin
        case (cpu_io_in[2:1])
            2'd0: begin m_pc <= 4'd0; m_acc <= 4'd0; m_ptr <= 4'd0; end
            2'd1: begin m_code[m_ptr] <= cpu_io_in[5:4]; m_ptr <= m_ptr + 4'd1; end
            2'd2: begin m_data[m_ptr] <= cpu_io_in[7:4]; m_ptr <= m_ptr + 4'd1; end
            default: begin
                case (m_code[m_pc])
                    2'd0: begin m_acc <= m_data[m_pc]; m_pc <= m_pc + 4'd1; end
                    2'd1: m_pc <= (m_acc != 4'd0) ? m_data[m_pc] : m_pc + 4'd1;
                    2'd2: begin m_acc <= m_acc + m_data[m_pc]; m_pc <= m_pc + 4'd1; end
                    default: m_pc <= m_data[m_pc];
                endcase
            end
        endcase
    end

    int cyc = 0;
    // Cycle counter for latency measurement.
    always @(posedge clock) cyc++;

    logic [7:0] mon_prev = 8'h00;
    int viol = 0, streak = 0, streak_at_run = 0, first_run_cyc = 0;
    // Command-port protocol monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (cpu_io_in[3] !== 1'b0) viol++;
        if (mon_prev[0] && cpu_io_in[0] && (mon_prev[7:1] !== cpu_io_in[7:1])) viol++;
        if (!mon_prev[0] && cpu_io_in[0]) begin
            if (cpu_io_in[2:1] != 2'd3) streak++;
            else if (streak != 0) begin
                streak_at_run = streak;
                first_run_cyc = cyc;
                streak = 0;
            end
        end
        mon_prev = cpu_io_in;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] prog_code [c_DEPTH];
    logic [3:0] prog_data [c_DEPTH];
    int         start_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the program alone: step until pc stops moving or budget ends.
    function automatic void ref_run(output bit h, output bit t, output int s, output logic [3:0] a);
        logic [3:0] pc, acc, pcb;
        pc = 4'd0; acc = 4'd0; h = 1'b0; t = 1'b0; s = 0;
        for (int k = 1; k <= c_MAXS; k++) begin
            pcb = pc;
            case (prog_code[pc])
                2'd0: begin acc = prog_data[pc]; pc = pc + 4'd1; end
                2'd1: pc = (acc != 4'd0) ? prog_data[pc] : pc + 4'd1;
                2'd2: begin acc = acc + prog_data[pc]; pc = pc + 4'd1; end
                default: pc = prog_data[pc];
            endcase
            s = k;
            if (pc == pcb) begin h = 1'b1; break; end
            if (k == c_MAXS) t = 1'b1;
        end
        a = acc;
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic feed(input int stall_w, input int abort_w, input bit rnd);
        int         n;
        logic [3:0] pc0;
        for (int w = 0; w < 2 * c_DEPTH; w++) begin
            if (w < c_DEPTH) in_data = {2'($urandom_range(0, 3)), prog_code[w]};
            else             in_data = prog_data[w - c_DEPTH];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin @(negedge clock); n++; end
            if (!in_ready) begin chk("ready_wait", 32'd0, 32'd1); in_valid = 1'b0; return; end
            if (w == abort_w) return;
            if (w == stall_w || (rnd && $urandom_range(0, 7) == 0)) begin
                pc0 = cpu_io_out[7:4];
                in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_ready", {31'd0, in_ready}, 32'd1);
                    chk("stall_cpuclk", {31'd0, cpu_clk}, 32'd0);
                    chk("stall_pc", {28'd0, cpu_io_out[7:4]}, {28'd0, pc0});
                end
                in_valid = 1'b1;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        bit         h, t, ok;
        int         s, n;
        logic [3:0] a;
        ref_run(h, t, s, a);
        n = 0;
        while (!done && n < 300) begin @(negedge clock); n++; end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, t});
        chk({tag, "_steps"}, {24'd0, steps}, s);
        chk({tag, "_acc"}, {28'd0, result_acc}, {28'd0, a});
        ok = 1'b1;
        for (int i = 0; i < c_DEPTH; i++)
            if (m_code[i] !== prog_code[i] || m_data[i] !== prog_data[i]) ok = 1'b0;
        chk({tag, "_mem"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic rand_prog();
        for (int i = 0; i < c_DEPTH; i++) begin
            prog_code[i] = 2'($urandom_range(0, 3));
            prog_data[i] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        int s0, n;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        repeat (3) @(negedge clock);
        chk("rst_io", {24'd0, cpu_io_in}, 32'h00);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_steps", {24'd0, steps}, 32'd0);
        chk("rst_acc", {28'd0, result_acc}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Halting program: Load 5, then Bnz to itself.
        for (int i = 0; i < c_DEPTH; i++) begin prog_code[i] = 2'd0; prog_data[i] = 4'd0; end
        prog_code[1] = 2'd1; prog_data[0] = 4'd5; prog_data[1] = 4'd1;
        start_pulse();
        chk("start_busy", {31'd0, busy}, 32'd1);
        feed(-1, -1, 1'b0);
        finish_run("halt");
        chk("halt_halted_c", {31'd0, halted}, 32'd1);
        chk("halt_steps_c", {24'd0, steps}, 32'd2);
        chk("halt_acc_c", {28'd0, result_acc}, 32'd5);
        chk("halt_latency", first_run_cyc - start_cyc, 32'd69);
        chk("halt_nonrun_rises", streak_at_run, 32'd34);

        // Timeout program: every word Load 0.
        for (int i = 0; i < c_DEPTH; i++) begin prog_code[i] = 2'd0; prog_data[i] = 4'd0; end
        start_pulse();
        feed(-1, -1, 1'b0);
        finish_run("tmo");
        chk("tmo_timeout_c", {31'd0, timeout}, 32'd1);
        chk("tmo_steps_c", {24'd0, steps}, c_MAXS);
        chk("tmo_nonrun_rises", streak_at_run, 32'd34);

        // Stall at word 7 of the data load.
        rand_prog();
        start_pulse();
        feed(c_DEPTH + 7, -1, 1'b0);
        finish_run("stall");

        // Reset in the middle of the code load, then a full reload.
        rand_prog();
        start_pulse();
        feed(-1, 4, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_io", {24'd0, cpu_io_in}, 32'h00);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < c_DEPTH; i++) prog_data[i] = 4'($urandom_range(0, 15));
        start_pulse();
        feed(-1, -1, 1'b0);
        finish_run("reload");

        // Start while busy is ignored; start in DONE restarts cleanly.
        for (int i = 0; i < c_DEPTH; i++) begin prog_code[i] = 2'd0; prog_data[i] = 4'd3; end
        start_pulse();
        feed(-1, -1, 1'b0);
        n = 0;
        while (steps < 8'd5 && n < 100) begin @(negedge clock); n++; end
        s0 = steps;
        start_pulse();
        chk("busy_start_busy", {31'd0, busy}, 32'd1);
        chk("busy_start_steps", {31'd0, (steps == s0) || (steps == s0 + 1)}, 32'd1);
        finish_run("busystart");
        start_pulse();
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_steps", {24'd0, steps}, 32'd0);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        chk("restart_timeout", {31'd0, timeout}, 32'd0);
        feed(-1, -1, 1'b0);
        finish_run("restart");

        // Random programs with random input stalls.
        for (int r = 0; r < 6; r++) begin
            rand_prog();
            if (r % 2 == 0) prog_code[$urandom_range(0, 15)] = 2'd3;
            start_pulse();
            feed(-1, -1, 1'b1);
            finish_run($sformatf("rand%0d", r));
        end

        chk("protocol_violations", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
